sync_debounce_bank: RTL and testbench
=====================================

// Module: sync_debounce_bank
// PURPOSE
//   Parametrised bank of CHANNELS input conditioners. Each channel has a STAGES-deep
//   synchronizer, a stable-count debounce filter and registered edge detectors.
//   It brings asynchronous buttons, switches and external strobes into the clk domain
//   for downstream FSMs. It gives one clean level per channel plus one-cycle rise/fall pulses.
// PARAMETERS
//   CHANNELS  4     number of independent input channels (>=1)
//   STAGES    2     synchronizer flops per channel (>=2)
//   DEBOUNCE  16    consecutive qualified mismatch samples needed to accept a new level (>=1)
//   INIT      0     CHANNELS-bit reset value of sync flops and level outputs, per bit
//   CNT_W     $clog2(DEBOUNCE+1)  debounce counter width (derived; do not override)
// PORTS
//   clk         in   1         system clock, all logic on posedge
//   rst         in   1         synchronous reset, active-high
//   async_in    in   CHANNELS  raw asynchronous inputs
//   sample_en   in   1         debounce qualifier; tie 1 for per-clock sampling
//   level       out  CHANNELS  debounced, synchronized level
//   rise        out  CHANNELS  1-cycle pulse when level goes 0->1
//   fall        out  CHANNELS  1-cycle pulse when level goes 1->0
//   any_change  out  1         |(rise|fall), combinational from registered pulses
// BEHAVIOUR
//   Reset (rst=1 at posedge): sync flops <= INIT, level <= INIT, counters <= 0,
//     rise <= 0, fall <= 0. Synchronous only; async_in is ignored while rst=1.
//   Sync chain, per channel, every posedge with rst=0:
//     s[0] <= async_in; s[i] <= s[i-1]; synced = s[STAGES-1].
//   Debounce, per channel, evaluated every posedge:
//     synced == level                -> cnt <= 0 (regardless of sample_en)
//     synced != level, sample_en=0   -> cnt holds
//     synced != level, sample_en=1, cnt <  DEBOUNCE-1 -> cnt <= cnt+1
//     synced != level, sample_en=1, cnt == DEBOUNCE-1 -> level <= synced, cnt <= 0
//   cnt never exceeds DEBOUNCE-1. No wrap is possible.
//   DEBOUNCE=1 gives no filtering: level follows synced one cycle later.
//   Latency: input stable from posedge 0 with sample_en=1 -> level updates at
//     posedge STAGES+DEBOUNCE-1.
//   Any sample with synced == level before acceptance restarts the count from 0.
//   Edge outputs are registered and asserted in the same cycle the new level is visible:
//     rise[i] <= ~level[i] & accept[i] & synced[i]; fall[i] <= level[i] & accept[i] & ~synced[i]
//     Each pulse lasts exactly 1 cycle. rise and fall are never both high on one channel.
//   Channels are fully independent. Simultaneous events on different channels produce
//     pulses in the same cycle.
//   Reset mid-count discards progress: no pulse, level = INIT.
//     After release, a level != INIT is re-qualified from scratch and produces a normal pulse.
// TESTING  (CHANNELS=4, STAGES=2, DEBOUNCE=4, INIT=4'h0, sample_en=1 unless noted)
//   1 Reset: async_in=4'hF, rst=1 for 3 cycles, then release ->
//     level=0 and rise=0 through posedge 4 after release;
//     level=4'hF and rise=4'hF at posedge 5, rise=0 at posedge 6.
//   2 Clean step: ch0 0->1 before posedge 0 ->
//     level[0]=1 and rise[0]=1 at posedge 5, single cycle; other channels quiet.
//   3 Glitch: ch1 high for 3 cycles then low -> level[1] stays 0, no rise/fall, any_change=0.
//   4 Bounce: ch2 sampled 1,0,1,1,1,1 ->
//     count restarts on the 0; rise[2] fires once, 4 posedges after the last restart seen at synced.
//   5 Qualifier: sample_en=0 with ch3 high -> level[3] never changes;
//     sample_en toggling 1,0,1,0 -> acceptance after 4 enabled samples, at posedge 8 of the toggle.
//   6 Mixed: level=4'b1000, then ch2 rises and ch3 falls in the same cycle ->
//     rise=4'b0100, fall=4'b1000 in one cycle, any_change=1.
//     Also: rst asserted when cnt=3 -> level stays INIT, no pulse.

Source files
------------

// File: rtl/sync_debounce_bank.sv
// sync_debounce_bank: per-channel synchronizer, stable-count debounce filter and registered rise/fall pulses.
module sync_debounce_bank #(
    parameter int                  CHANNELS = 4,
    parameter int                  STAGES   = 2,
    parameter int                  DEBOUNCE = 16,
    parameter logic [CHANNELS-1:0] INIT     = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] async_in,
    input  logic                sample_en,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                any_change
);
    localparam int              CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE - 1);
    logic [CHANNELS-1:0] sync_q [STAGES];
    logic [CNT_W-1:0]    cnt_q  [CHANNELS];
    logic [CNT_W-1:0]    cnt_d  [CHANNELS];
    logic [CHANNELS-1:0] level_q, level_d, rise_q, rise_d, fall_q, fall_d;
    logic [CHANNELS-1:0] synced, differ, accept;
    always_comb begin
        synced = sync_q[STAGES-1];
        differ = synced ^ level_q;
        accept = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            accept[c] = differ[c] & sample_en & (cnt_q[c] == LAST);
            // a matching sample or an acceptance both restart the count
            cnt_d[c] = (!differ[c] || accept[c]) ? '0 : sample_en ? cnt_q[c] + 1'b1 : cnt_q[c];
        end
        level_d = level_q ^ accept;
        rise_d  = ~level_q & accept & synced;
        fall_d  = level_q & accept & ~synced;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) sync_q[s] <= INIT;
            for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= '0;
            level_q <= INIT;
            rise_q  <= '0;
            fall_q  <= '0;
        end else begin
            sync_q[0] <= async_in;
            for (int s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
            for (int c = 0; c < CHANNELS; c++) cnt_q[c] <= cnt_d[c];
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end
    assign level      = level_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign any_change = |(rise_q | fall_q);
endmodule

// File: tb/tb_sync_debounce_bank.sv
// tb_sync_debounce_bank: directed scenarios for the debounce bank (CHANNELS=4, STAGES=2, DEBOUNCE=4).
module tb_sync_debounce_bank;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] async_in = 4'h0;
    logic       sample_en = 1'b1;
    logic [3:0] level, rise, fall;
    logic       any_change;
    int         checks = 0;
    int         failures = 0;

    sync_debounce_bank #(.CHANNELS(4), .STAGES(2), .DEBOUNCE(4), .INIT(4'h0)) dut (
        .clk(clk), .rst(rst), .async_in(async_in), .sample_en(sample_en),
        .level(level), .rise(rise), .fall(fall), .any_change(any_change)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] v);
        rst = 1'b1;
        async_in = v;
        sample_en = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        async_in = 4'hF;
        repeat (3) step();
        checks++;
        if (level !== 4'h0 || rise !== 4'h0 || fall !== 4'h0) begin
            failures++;
            $display("FAIL reset_hold level=%h rise=%h fall=%h required 0/0/0", level, rise, fall);
        end
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (level !== 4'h0 || rise !== 4'h0) begin
                failures++;
                $display("FAIL reset_quiet p%0d level=%h rise=%h required 0/0", k, level, rise);
            end
        end
        step();
        checks++;
        if (level !== 4'hF || rise !== 4'hF || fall !== 4'h0) begin
            failures++;
            $display("FAIL reset_accept level=%h rise=%h fall=%h required f/f/0", level, rise, fall);
        end
        step();
        checks++;
        if (rise !== 4'h0 || level !== 4'hF) begin
            failures++;
            $display("FAIL reset_pulse_end level=%h rise=%h required f/0", level, rise);
        end
    endtask

    task automatic test_clean_step();
        do_reset(4'h0);
        async_in = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (level !== 4'h0 || rise !== 4'h0 || any_change !== 1'b0) begin
                failures++;
                $display("FAIL step_wait p%0d level=%h rise=%h any=%b required 0/0/0", k, level, rise, any_change);
            end
        end
        step();
        checks++;
        if (level !== 4'b0001 || rise !== 4'b0001 || fall !== 4'h0 || any_change !== 1'b1) begin
            failures++;
            $display("FAIL step_accept level=%h rise=%h fall=%h any=%b required 1/1/0/1", level, rise, fall, any_change);
        end
        step();
        checks++;
        if (level !== 4'b0001 || rise !== 4'h0 || any_change !== 1'b0) begin
            failures++;
            $display("FAIL step_single level=%h rise=%h any=%b required 1/0/0", level, rise, any_change);
        end
    endtask

    task automatic test_glitch();
        do_reset(4'h0);
        async_in = 4'b0010;
        for (int k = 0; k < 12; k++) begin
            step();
            if (k == 2) async_in = 4'h0;
            checks++;
            if (level !== 4'h0 || rise !== 4'h0 || fall !== 4'h0 || any_change !== 1'b0) begin
                failures++;
                $display("FAIL glitch p%0d level=%h rise=%h fall=%h any=%b required all 0", k, level, rise, fall, any_change);
            end
        end
    endtask

    task automatic test_bounce();
        logic [5:0] pat;
        pat = 6'b111101;
        do_reset(4'h0);
        for (int k = 0; k < 9; k++) begin
            async_in = (k < 6) ? {1'b0, pat[k], 2'b00} : 4'b0100;
            step();
            if (k < 7) begin
                checks++;
                if (rise !== 4'h0 || level !== 4'h0) begin
                    failures++;
                    $display("FAIL bounce_wait p%0d level=%h rise=%h required 0/0", k, level, rise);
                end
            end else if (k == 7) begin
                checks++;
                if (rise !== 4'b0100 || level !== 4'b0100) begin
                    failures++;
                    $display("FAIL bounce_accept level=%h rise=%h required 4/4", level, rise);
                end
            end else begin
                checks++;
                if (rise !== 4'h0 || level !== 4'b0100) begin
                    failures++;
                    $display("FAIL bounce_single level=%h rise=%h required 4/0", level, rise);
                end
            end
        end
    endtask

    task automatic test_qualifier();
        do_reset(4'h0);
        sample_en = 1'b0;
        async_in = 4'b1000;
        repeat (12) step();
        checks++;
        if (level !== 4'h0 || rise !== 4'h0) begin
            failures++;
            $display("FAIL qual_disabled level=%h rise=%h required 0/0", level, rise);
        end
        do_reset(4'h0);
        async_in = 4'b1000;
        for (int k = 0; k < 10; k++) begin
            sample_en = (k % 2 == 0);
            step();
            if (k < 8) begin
                checks++;
                if (level !== 4'h0 || rise !== 4'h0) begin
                    failures++;
                    $display("FAIL qual_wait p%0d level=%h rise=%h required 0/0", k, level, rise);
                end
            end else if (k == 8) begin
                checks++;
                if (level !== 4'b1000 || rise !== 4'b1000) begin
                    failures++;
                    $display("FAIL qual_accept level=%h rise=%h required 8/8", level, rise);
                end
            end
        end
        sample_en = 1'b1;
    endtask

    task automatic test_mixed();
        do_reset(4'b1000);
        repeat (7) step();
        checks++;
        if (level !== 4'b1000) begin
            failures++;
            $display("FAIL mixed_setup level=%h required 8", level);
        end
        async_in = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (rise !== 4'h0 || fall !== 4'h0 || level !== 4'b1000) begin
                failures++;
                $display("FAIL mixed_wait p%0d level=%h rise=%h fall=%h required 8/0/0", k, level, rise, fall);
            end
        end
        step();
        checks++;
        if (rise !== 4'b0100 || fall !== 4'b1000 || any_change !== 1'b1 || level !== 4'b0100) begin
            failures++;
            $display("FAIL mixed_accept level=%h rise=%h fall=%h any=%b required 4/4/8/1", level, rise, fall, any_change);
        end
        step();
        checks++;
        if (rise !== 4'h0 || fall !== 4'h0 || any_change !== 1'b0) begin
            failures++;
            $display("FAIL mixed_single rise=%h fall=%h any=%b required 0/0/0", rise, fall, any_change);
        end
    endtask

    task automatic test_reset_mid_count();
        do_reset(4'h0);
        async_in = 4'b0001;
        repeat (5) step();
        rst = 1'b1;
        step();
        checks++;
        if (level !== 4'h0 || rise !== 4'h0 || any_change !== 1'b0) begin
            failures++;
            $display("FAIL midrst_discard level=%h rise=%h any=%b required 0/0/0", level, rise, any_change);
        end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (k < 5 && (level !== 4'h0 || rise !== 4'h0)) begin
                failures++;
                $display("FAIL midrst_wait p%0d level=%h rise=%h required 0/0", k, level, rise);
            end else if (k == 5 && (level !== 4'b0001 || rise !== 4'b0001)) begin
                failures++;
                $display("FAIL midrst_requalify level=%h rise=%h required 1/1", level, rise);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_glitch();
        test_bounce();
        test_qualifier();
        test_mixed();
        test_reset_mid_count();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
